// File: rtl/microseq_pkg.sv
// Shared constants for the RVS9 micro-sequencer: next-uPC codes, microword layout,
// the default control-store program and the opcode dispatch table.
package microseq_pkg;

  localparam logic [1:0] NXT_SEQ   = 2'b00;
  localparam logic [1:0] NXT_DISP  = 2'b01;
  localparam logic [1:0] NXT_FETCH = 2'b10;
  localparam logic [1:0] NXT_BR    = 2'b11;

  // The stored program is authored at these widths; micro_rom adapts to the instance widths.
  localparam int ROM_UPC_W  = 4;
  localparam int ROM_CTRL_W = 11;
  localparam int ROM_SEL_W  = 2;
  localparam int ROM_DEPTH  = 2 ** ROM_UPC_W;
  localparam int DISP_OPC_W = 4;
  localparam int DISP_DEPTH = 2 ** DISP_OPC_W;

  typedef struct packed {
    logic [ROM_CTRL_W-1:0] ctrl;
    logic [ROM_SEL_W-1:0]  sel;
    logic                  we;
    logic [1:0]            nxt;
    logic [ROM_UPC_W-1:0]  target;
  } uword_t;

  typedef struct packed {
    logic                 valid;
    logic [ROM_UPC_W-1:0] target;
  } disp_ent_t;

  localparam uword_t UW_IDLE = '{11'h000, 2'd0, 1'b0, NXT_FETCH, 4'd0};

  localparam uword_t DEFAULT_ROM [ROM_DEPTH] = '{
    '{11'h001, 2'd0, 1'b0, NXT_SEQ,   4'd0},   // 0  FETCH
    '{11'h002, 2'd0, 1'b0, NXT_SEQ,   4'd0},   // 1  DECODE
    '{11'h004, 2'd0, 1'b0, NXT_DISP,  4'd0},   // 2  dispatch on opcode
    '{11'h010, 2'd0, 1'b0, NXT_SEQ,   4'd0},   // 3  rr: read field0
    '{11'h020, 2'd1, 1'b0, NXT_SEQ,   4'd0},   // 4  rr: read field1, execute
    '{11'h040, 2'd2, 1'b1, NXT_FETCH, 4'd0},   // 5  rr: write field2
    '{11'h080, 2'd0, 1'b0, NXT_SEQ,   4'd0},   // 6  ri: read field0
    '{11'h100, 2'd1, 1'b0, NXT_SEQ,   4'd0},   // 7  ri: execute with immediate
    '{11'h200, 2'd1, 1'b1, NXT_FETCH, 4'd0},   // 8  ri: write field1
    '{11'h400, 2'd0, 1'b0, NXT_BR,    4'd11},  // 9  branch test
    '{11'h008, 2'd0, 1'b0, NXT_FETCH, 4'd0},   // 10 branch not taken
    '{11'h018, 2'd0, 1'b0, NXT_FETCH, 4'd0},   // 11 branch taken
    UW_IDLE, UW_IDLE, UW_IDLE, UW_IDLE
  };

  localparam disp_ent_t DISP_NONE = '{1'b0, 4'd0};

  localparam disp_ent_t DEFAULT_DISP [DISP_DEPTH] = '{
    '{1'b1, 4'd3}, '{1'b1, 4'd6}, '{1'b1, 4'd9}, DISP_NONE,
    DISP_NONE, DISP_NONE, DISP_NONE, DISP_NONE,
    DISP_NONE, DISP_NONE, DISP_NONE, DISP_NONE,
    DISP_NONE, DISP_NONE, DISP_NONE, DISP_NONE
  };

endpackage

// File: rtl/micro_rom.sv
// Combinational control store: maps a uPC to the fields of its microword.
// Locations beyond the stored program read as an inert FETCH word.
module micro_rom
  import microseq_pkg::*;
#(
  parameter int UPC_W  = 4,
  parameter int CTRL_W = 11,
  parameter int SEL_W  = 2
) (
  input  logic [UPC_W-1:0]  upc_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              we_o,
  output logic [1:0]        nxt_o,
  output logic [UPC_W-1:0]  target_o
);

  logic [ROM_UPC_W-1:0] ridx;
  uword_t               uw;

  always_comb begin
    ridx = ROM_UPC_W'(upc_i);
    uw   = UW_IDLE;
    if (32'(upc_i) < 32'(ROM_DEPTH)) uw = DEFAULT_ROM[ridx];
    ctrl_o   = CTRL_W'(uw.ctrl);
    sel_o    = SEL_W'(uw.sel);
    we_o     = uw.we;
    nxt_o    = uw.nxt;
    target_o = UPC_W'(uw.target);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcoded control unit: valid/ready instruction intake, opcode dispatch, stall,
// conditional branch and illegal-opcode pulse. Optional retire counter: MICROSEQ_RETIRE_CNT_EN.
module micro_sequencer
  import microseq_pkg::*;
#(
  parameter int UPC_W      = 4,
  parameter int OPC_W      = 4,
  parameter int REG_W      = 5,
  parameter int NUM_FIELDS = 3,
  parameter int CTRL_W     = 11,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [OPC_W-1:0]            instr_opcode,
  input  logic [NUM_FIELDS*REG_W-1:0] instr_regs,
  input  logic                        stall,
  input  logic                        cond,
  output logic [CTRL_W-1:0]           ctrl_en,
  output logic [REG_W-1:0]            reg_addr,
  output logic                        reg_we,
  output logic [UPC_W-1:0]            upc,
  output logic                        illegal_op
`ifdef MICROSEQ_RETIRE_CNT_EN
  ,output logic [CNT_W-1:0]           retired_cnt
`endif
);

  localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  logic [UPC_W-1:0]            upc_q, upc_d;
  logic [OPC_W-1:0]            opcode_q, opcode_d;
  logic [NUM_FIELDS*REG_W-1:0] regs_q, regs_d;

  logic [CTRL_W-1:0] rom_ctrl;
  logic [SEL_W-1:0]  rom_sel;
  logic              rom_we;
  logic [1:0]        rom_nxt;
  logic [UPC_W-1:0]  rom_target;

  logic             accept, active, from_busy, wrap, retire_evt;
  logic             disp_valid;
  logic [UPC_W-1:0] disp_target, upc_inc;
  logic [DISP_OPC_W-1:0] didx;
  disp_ent_t        dent;

  micro_rom #(
    .UPC_W  (UPC_W),
    .CTRL_W (CTRL_W),
    .SEL_W  (SEL_W)
  ) u_rom (
    .upc_i    (upc_q),
    .ctrl_o   (rom_ctrl),
    .sel_o    (rom_sel),
    .we_o     (rom_we),
    .nxt_o    (rom_nxt),
    .target_o (rom_target)
  );

  // A microword executes when not stalled and either mid-instruction or taking an instruction.
  assign instr_ready = (upc_q == '0) & ~stall;
  assign accept      = instr_valid & instr_ready;
  assign active      = ~stall & ((upc_q != '0) | accept);
  assign from_busy   = (upc_q != '0);
  assign wrap        = &upc_q;
  assign upc_inc     = upc_q + 1'b1;
  assign upc         = upc_q;

  always_comb begin
    didx = DISP_OPC_W'(opcode_q);
    dent = DISP_NONE;
    if (32'(opcode_q) < 32'(DISP_DEPTH)) dent = DEFAULT_DISP[didx];
    disp_valid  = dent.valid;
    disp_target = UPC_W'(dent.target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q    <= '0;
      opcode_q <= '0;
      regs_q   <= '0;
    end else begin
      upc_q    <= upc_d;
      opcode_q <= opcode_d;
      regs_q   <= regs_d;
    end
  end

  // Incrementing past the last location wraps to FETCH and completes the instruction.
  always_comb begin
    upc_d      = upc_q;
    opcode_d   = opcode_q;
    regs_d     = regs_q;
    retire_evt = 1'b0;
    if (accept) begin
      opcode_d = instr_opcode;
      regs_d   = instr_regs;
    end
    if (active) begin
      case (rom_nxt)
        NXT_SEQ: begin
          upc_d      = upc_inc;
          retire_evt = from_busy & wrap;
        end
        NXT_DISP: begin
          upc_d = disp_valid ? disp_target : '0;
        end
        NXT_FETCH: begin
          upc_d      = '0;
          retire_evt = from_busy;
        end
        default: begin
          upc_d      = cond ? rom_target : upc_inc;
          retire_evt = from_busy & ~cond & wrap;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_en    = '0;
    reg_we     = 1'b0;
    illegal_op = 1'b0;
    reg_addr   = regs_q[REG_W-1:0];
    if (active) begin
      ctrl_en    = rom_ctrl;
      reg_we     = rom_we;
      illegal_op = (rom_nxt == NXT_DISP) & ~disp_valid;
    end
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (rom_sel == SEL_W'(k)) reg_addr = regs_q[k*REG_W +: REG_W];
    end
  end

`ifdef MICROSEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d       = retire_evt ? cnt_q + 1'b1 : cnt_q;
  assign retired_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_retire;
  assign unused_retire = retire_evt ^ CNT_W[0];
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: per-cycle expectations are queued when an
// instruction is planned and popped/compared as the sequencer steps through it.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_opcode;
  logic [14:0] instr_regs;
  logic        stall;
  logic        cond;
  logic [10:0] ctrl_en;
  logic [4:0]  reg_addr;
  logic        reg_we;
  logic [3:0]  upc;
  logic        illegal_op;
`ifdef MICROSEQ_RETIRE_CNT_EN
  logic [1:0]  retired_cnt;
`endif

  micro_sequencer #(
    .UPC_W(4), .OPC_W(4), .REG_W(5), .NUM_FIELDS(3), .CTRL_W(11), .CNT_W(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_regs   (instr_regs),
    .stall        (stall),
    .cond         (cond),
    .ctrl_en      (ctrl_en),
    .reg_addr     (reg_addr),
    .reg_we       (reg_we),
    .upc          (upc),
    .illegal_op   (illegal_op)
`ifdef MICROSEQ_RETIRE_CNT_EN
    ,.retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;

  typedef struct packed {
    logic       stall;
    logic [3:0] upc;
    logic       ready;
    logic       we;
    logic       ill;
    logic       chk_addr;
    logic [4:0] addr;
    logic       ctrl_on;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ret();
`ifdef MICROSEQ_RETIRE_CNT_EN
    chk("retired_cnt", 32'(retired_cnt), 32'(exp_ret));
`endif
  endtask

  // Reference program paths, written from the microprogram description.
  task automatic plan(input logic [3:0] op, input logic [14:0] regs, input bit cnd,
                      input int stall_upc, input int stall_n);
    int   path[$];
    exp_t e;
    logic [4:0] a;
    path = {0, 1, 2};
    case (op)
      4'd0:    path = {path, 3, 4, 5};
      4'd1:    path = {path, 6, 7, 8};
      4'd2:    path = {path, 9, (cnd ? 11 : 10)};
      default: ;
    endcase
    foreach (path[i]) begin
      a = '0;
      if (path[i] >= 3 && path[i] <= 5) a = regs[(path[i]-3)*5 +: 5];
      if (path[i] == stall_upc) begin
        for (int s = 0; s < stall_n; s++) begin
          e = '{1'b1, 4'(path[i]), 1'b0, 1'b0, 1'b0,
                (path[i] >= 3 && path[i] <= 5), a, 1'b0};
          sb.push_back(e);
        end
      end
      e = '{1'b0, 4'(path[i]), (path[i] == 0), (path[i] == 5 || path[i] == 8),
            (path[i] == 2 && op > 4'd2), (path[i] >= 3 && path[i] <= 5), a, 1'b1};
      sb.push_back(e);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [14:0] regs, input bit cnd,
                           input int stall_upc, input int stall_n, input int abort_upc);
    exp_t e;
    bit   first = 1'b1;
    bit   aborted = 1'b0;
    plan(op, regs, cnd, stall_upc, stall_n);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      stall        = e.stall;
      instr_valid  = first;
      instr_opcode = op;
      instr_regs   = regs;
      cond         = cnd;
      #1;
      if (first) chk_ret();
      first = 1'b0;
      chk("upc", 32'(upc), 32'(e.upc));
      chk("instr_ready", 32'(instr_ready), 32'(e.ready));
      chk("reg_we", 32'(reg_we), 32'(e.we));
      chk("illegal_op", 32'(illegal_op), 32'(e.ill));
      chk("ctrl_active", 32'(ctrl_en != '0), 32'(e.ctrl_on));
      if (e.chk_addr) chk("reg_addr", 32'(reg_addr), 32'(e.addr));
      if (32'(e.upc) == abort_upc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_upc", 32'(upc), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        sb.delete();
        exp_ret = 0;
        aborted = 1'b1;
      end
    end
    instr_valid = 1'b0;
    stall       = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_upc", 32'(upc), 32'd0);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
      chk_ret();
    end else if (op <= 4'd2) begin
      exp_ret = (exp_ret + 1) % 4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_regs   = '0;
    stall        = 1'b0;
    cond         = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_upc", 32'(upc), 32'd0);
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_upc", 32'(upc), 32'd0);
    chk("idle_ready", 32'(instr_ready), 32'd1);
    chk("idle_ctrl", 32'(ctrl_en), 32'd0);
    chk("idle_we", 32'(reg_we), 32'd0);
    chk_ret();
    stall = 1'b1;
    #1;
    chk("idle_stall_ready", 32'(instr_ready), 32'd0);
    stall = 1'b0;

    run_instr(4'd0,  {5'd7, 5'd2, 5'd1},    1'b0, -1, 0, -1);
    run_instr(4'd2,  {5'd4, 5'd5, 5'd6},    1'b1, -1, 0, -1);
    run_instr(4'd2,  {5'd4, 5'd5, 5'd6},    1'b0, -1, 0, -1);
    run_instr(4'd15, {5'd31, 5'd30, 5'd29}, 1'b0, -1, 0, -1);
    run_instr(4'd0,  {5'd3, 5'd9, 5'd17},   1'b0,  4, 3, -1);
    run_instr(4'd1,  {5'd8, 5'd12, 5'd20},  1'b1, -1, 0, -1);
    run_instr(4'd1,  {5'd1, 5'd2, 5'd3},    1'b0, -1, 0,  7);
    run_instr(4'd1,  {5'd11, 5'd13, 5'd19}, 1'b0, -1, 0, -1);

    @(negedge clk);
    #1;
    chk("final_upc", 32'(upc), 32'd0);
    chk_ret();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
